// File: rtl/fifo_occ_pkg.sv
// Shared types and helpers for the
// multi-channel FIFO occupancy monitor.
package fifo_occ_pkg;

  typedef enum logic [2:0] {
    UPD_HOLD,
    UPD_INC,
    UPD_DEC,
    UPD_OVF,
    UPD_UDF
  } upd_e;

  function automatic int cnt_width(
    input int depth
  );
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fifo_occ_chan.sv
// One channel: saturating occupancy count,
// level flags, sticky errors, high-water mark.
module fifo_occ_chan
  import fifo_occ_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2,
  parameter int CW     = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          clr,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic          ovf_err,
  output logic          udf_err,
  output logic [CW-1:0] hwm
);

  upd_e          upd;
  logic [CW-1:0] cnt_nxt;

  // Level flags decode straight off the count register
  assign full         = count == CW'(DEPTH);
  assign empty        = count == '0;
  assign almost_full  = count >= CW'(AF_LVL);
  assign almost_empty = count <= CW'(AE_LVL);

  // Classify this cycle's strobes; push+pop together is a pass-through
  always_comb begin
    upd = UPD_HOLD;
    unique case (1'b1)
      push && !pop && !full:  upd = UPD_INC;
      push && !pop && full:   upd = UPD_OVF;
      !push && pop && !empty: upd = UPD_DEC;
      !push && pop && empty:  upd = UPD_UDF;
      default:                upd = UPD_HOLD;
    endcase
  end

  // Next count; overflow/underflow saturate by holding
  always_comb begin
    cnt_nxt = count;
    if (upd == UPD_INC)
      cnt_nxt = count + CW'(1);
    else if (upd == UPD_DEC)
      cnt_nxt = count - CW'(1);
  end

  // Count, sticky errors (set beats clear) and high-water mark
  always_ff @(posedge clk) begin
    if (rst) begin
      count   <= '0;
      ovf_err <= 1'b0;
      udf_err <= 1'b0;
      hwm     <= '0;
    end else begin
      count   <= cnt_nxt;
      ovf_err <= (upd == UPD_OVF) | (ovf_err & ~clr);
      udf_err <= (upd == UPD_UDF) | (udf_err & ~clr);
      if (clr || cnt_nxt > hwm)
        hwm <= cnt_nxt;
    end
  end

  // Report saturation events for debug
  always @(posedge clk) begin
    if (!rst && upd == UPD_OVF)
      $warning("%m: overflow at %0t, count=%0d",
               $time, count);
    if (!rst && upd == UPD_UDF)
      $warning("%m: underflow at %0t, count=%0d",
               $time, count);
  end

  a_cnt_range: assert property (
    @(posedge clk) disable iff (rst)
    count <= CW'(DEPTH)
  ) else $error("%m: count %0d > DEPTH", count);

endmodule

// File: rtl/fifo_occ_monitor.sv
// Multi-channel FIFO occupancy monitor:
// NCH independent channels plus a global error OR.
module fifo_occ_monitor
  import fifo_occ_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int DEPTH  = 16,
  parameter int AF_LVL = 14,
  parameter int AE_LVL = 2,
  parameter int CW     = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NCH-1:0]    push,
  input  logic [NCH-1:0]    pop,
  input  logic [NCH-1:0]    clr,
  output logic [NCH*CW-1:0] fifo_count,
  output logic [NCH-1:0]    full,
  output logic [NCH-1:0]    empty,
  output logic [NCH-1:0]    almost_full,
  output logic [NCH-1:0]    almost_empty,
  output logic [NCH-1:0]    ovf_err,
  output logic [NCH-1:0]    udf_err,
  output logic [NCH*CW-1:0] hwm,
  output logic              any_err
);

  if (!(AE_LVL < AF_LVL && AF_LVL <= DEPTH)) begin : g_bad_lvl
    $fatal(1, "need AE_LVL < AF_LVL <= DEPTH");
  end

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    fifo_occ_chan #(
      .DEPTH  (DEPTH),
      .AF_LVL (AF_LVL),
      .AE_LVL (AE_LVL),
      .CW     (CW)
    ) u_chan (
      .clk          (clk),
      .rst          (rst),
      .push         (push[i]),
      .pop          (pop[i]),
      .clr          (clr[i]),
      .count        (fifo_count[i*CW +: CW]),
      .full         (full[i]),
      .empty        (empty[i]),
      .almost_full  (almost_full[i]),
      .almost_empty (almost_empty[i]),
      .ovf_err      (ovf_err[i]),
      .udf_err      (udf_err[i]),
      .hwm          (hwm[i*CW +: CW])
    );
  end

  // Any sticky error on any channel
  assign any_err = |{ovf_err, udf_err};

endmodule
